vram_arb: RTL and testbench

VRAM_ARB -- requirements
Module: vram_arb

---
 rtl/ppu_pkg.sv | 23 ++
 rtl/vram_ptr.sv | 35 +++
 rtl/vram_arb.sv | 123 ++++++++++++
 tb/tb_vram_arb.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU VRAM-arbiter types and constants: FSM state encoding, palette base, pointer steps.
package ppu_pkg;

  localparam int VADDR_W = 14;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    ACCESS    = 2'd2,
    CAPTURE   = 2'd3
  } arb_state_e;

  localparam logic [VADDR_W-1:0] PAL_BASE = 14'h3F00;
  localparam logic [VADDR_W-1:0] STEP_1   = 14'd1;
  localparam logic [VADDR_W-1:0] STEP_32  = 14'd32;

  // Wraps naturally at 2^14 because the result is truncated to VADDR_W bits.
  function automatic logic [VADDR_W-1:0] ptr_step(input logic [VADDR_W-1:0] p,
                                                   input logic inc32);
    return p + (inc32 ? STEP_32 : STEP_1);
  endfunction

endpackage

// File: rtl/vram_ptr.sv
// CPU VRAM pointer (PPUADDR): loadable, steps by 1 or 32; a load beats a coincident step.
module vram_ptr
  import ppu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [VADDR_W-1:0] load_addr_i,
  input  logic               step_i,
  input  logic               inc32_i,
  output logic [VADDR_W-1:0] ptr_o
);

  logic [VADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_addr_i;
    end else if (step_i) begin
      ptr_d = ptr_step(ptr_q, inc32_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/vram_arb.sv
// PPUDATA / renderer VRAM arbiter with one-read-delayed buffer.
// Optional macro PPU_PAL_BYPASS_EN: palette reads return pal_rdata directly.
module vram_arb
  import ppu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rend,
  input  logic               fetch_bg,
  input  logic [VADDR_W-1:0] render_addr,
  input  logic               addr_load,
  input  logic [VADDR_W-1:0] addr_i,
  input  logic               inc32,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_busy,
  output logic [VADDR_W-1:0] vram_addr,
  output logic               vram_rd,
  output logic               vram_we,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  input  logic [5:0]         pal_rdata
);

  arb_state_e         state_q, state_d;
  logic               we_q, we_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [VADDR_W-1:0] addr_q, addr_d;
  logic [7:0]         buf_q, buf_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               step;
  logic [VADDR_W-1:0] ptr;
  logic [7:0]         read_value;

  vram_ptr u_ptr (
    .clk_i       (clk),
    .rst_ni      (rst),
    .load_i      (addr_load),
    .load_addr_i (addr_i),
    .step_i      (step),
    .inc32_i     (inc32),
    .ptr_o       (ptr)
  );

`ifdef PPU_PAL_BYPASS_EN
  assign read_value = (ptr >= PAL_BASE) ? {2'b00, pal_rdata} : buf_q;
`else
  logic unused_pal;
  assign unused_pal = ^pal_rdata;
  assign read_value = buf_q;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          addr_d  = ptr;
          if (!cpu_we) begin
            rdata_d = read_value;
          end
          state_d = WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        // Renderer keeps the bus for every cycle it is actively fetching.
        if (!rend || !fetch_bg) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          step    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        buf_d   = vram_rdata;
        step    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu_busy   = (state_q != IDLE);
  assign cpu_rdata  = rdata_q;
  assign vram_addr  = (state_q == ACCESS) ? addr_q : render_addr;
  assign vram_rd    = (state_q == ACCESS) && !we_q;
  assign vram_we    = (state_q == ACCESS) && we_q;
  assign vram_wdata = wdata_q;

endmodule

// File: tb/tb_vram_arb.sv
// Directed self-checking bench for vram_arb; honours PPU_PAL_BYPASS_EN for the palette case.
module tb_vram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rend, fetch_bg, addr_load, inc32, cpu_req, cpu_we;
  logic [13:0] render_addr, addr_i;
  logic [7:0]  cpu_wdata, cpu_rdata, vram_wdata, vram_rdata;
  logic        cpu_busy, vram_rd, vram_we;
  logic [13:0] vram_addr;
  logic [5:0]  pal_rdata;

  int n_chk = 0;
  int n_err = 0;

  int          s_cyc, s_cnt, i_cyc, fb_viol;
  logic [13:0] s_addr;
  logic [7:0]  s_wd;
  logic        s_rd;
  logic [7:0]  exp_pal;

  always #5 clk = ~clk;

  vram_arb dut (
    .clk         (clk),
    .rst         (rst),
    .rend        (rend),
    .fetch_bg    (fetch_bg),
    .render_addr (render_addr),
    .addr_load   (addr_load),
    .addr_i      (addr_i),
    .inc32       (inc32),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_busy    (cpu_busy),
    .vram_addr   (vram_addr),
    .vram_rd     (vram_rd),
    .vram_we     (vram_we),
    .vram_wdata  (vram_wdata),
    .vram_rdata  (vram_rdata),
    .pal_rdata   (pal_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_ptr(input logic [13:0] a);
    @(posedge clk); #1;
    addr_load = 1'b1;
    addr_i    = a;
    @(posedge clk); #1;
    addr_load = 1'b0;
  endtask

  // Request in cycle 0; cpu_req held req_hold cycles, fetch_bg held fb_hold cycles.
  task automatic access(input logic we, input logic [7:0] wd, input int fb_hold, input int req_hold);
    s_cyc = -1; s_cnt = 0; i_cyc = -1; fb_viol = 0;
    s_addr = '0; s_wd = '0; s_rd = 1'b0;
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_wdata = wd;
    fetch_bg  = (fb_hold > 0);
    for (int c = 1; c <= 30 && i_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (c >= req_hold) cpu_req = 1'b0;
      fetch_bg = (c < fb_hold);
      @(negedge clk);
      if (rend && fetch_bg && (vram_addr !== render_addr || vram_rd || vram_we)) fb_viol++;
      if (vram_rd || vram_we) begin
        s_cnt++;
        if (s_cyc < 0) begin
          s_cyc = c; s_addr = vram_addr; s_wd = vram_wdata; s_rd = vram_rd;
        end
      end
      if (!cpu_busy) i_cyc = c;
    end
    cpu_req  = 1'b0;
    fetch_bg = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (vram_rd || vram_we || cpu_busy) s_cnt++;
    end
  endtask

  initial begin
    rst = 1'b0; rend = 1'b0; fetch_bg = 1'b0; addr_load = 1'b0; inc32 = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0; render_addr = 14'h1111;
    addr_i = '0; vram_rdata = '0; pal_rdata = '0;
    #12;
    chk("rst_busy", cpu_busy, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_strobes", {vram_rd, vram_we}, 0);
    chk("rst_wdata", vram_wdata, 0);
    chk("rst_addr", vram_addr, 14'h1111);
    @(negedge clk); rst = 1'b1;

    // Idle bus write at 2000, then a second write shows the +1 step
    load_ptr(14'h2000);
    access(1'b1, 8'hA5, 0, 1);
    chk("w1_cyc", s_cyc, 2);
    chk("w1_addr", s_addr, 14'h2000);
    chk("w1_data", s_wd, 8'hA5);
    chk("w1_kind", s_rd, 0);
    chk("w1_idle", i_cyc, 3);
    chk("w1_cnt", s_cnt, 1);
    access(1'b1, 8'h5C, 0, 1);
    chk("w2_addr", s_addr, 14'h2001);

    // Buffered reads with +32 stepping
    inc32 = 1'b1;
    load_ptr(14'h23C0);
    vram_rdata = 8'h11;
    access(1'b0, 8'h00, 0, 1);
    chk("r1_cyc", s_cyc, 2);
    chk("r1_addr", s_addr, 14'h23C0);
    chk("r1_kind", s_rd, 1);
    chk("r1_idle", i_cyc, 4);
    chk("r1_rdata", cpu_rdata, 8'h00);
    vram_rdata = 8'h22;
    access(1'b0, 8'h00, 0, 1);
    chk("r2_addr", s_addr, 14'h23E0);
    chk("r2_rdata", cpu_rdata, 8'h11);
    vram_rdata = 8'h33;
    access(1'b0, 8'h00, 0, 1);
    chk("r3_addr", s_addr, 14'h2400);
    chk("r3_rdata", cpu_rdata, 8'h22);

    // Renderer fetching for 5 cycles holds off the CPU read
    rend = 1'b1; inc32 = 1'b0; render_addr = 14'h0AAA; vram_rdata = 8'h44;
    access(1'b0, 8'h00, 5, 1);
    chk("fb_cyc", s_cyc, 6);
    chk("fb_addr", s_addr, 14'h2420);
    chk("fb_viol", fb_viol, 0);
    chk("fb_idle", i_cyc, 8);
    chk("fb_rdata", cpu_rdata, 8'h33);

    // Wrap at 3FFF and cpu_req held during busy
    rend = 1'b0;
    load_ptr(14'h3FFF);
    access(1'b1, 8'h77, 0, 3);
    chk("wrap_addr", s_addr, 14'h3FFF);
    chk("busy_cnt", s_cnt, 1);
    chk("busy_idle", i_cyc, 3);
    access(1'b1, 8'h78, 0, 1);
    chk("wrap_next", s_addr, 14'h0000);

    // Palette-range read
`ifdef PPU_PAL_BYPASS_EN
    exp_pal = 8'h2A;
`else
    exp_pal = 8'h44;
`endif
    load_ptr(14'h3F01);
    pal_rdata = 6'h2A; vram_rdata = 8'h55;
    access(1'b0, 8'h00, 0, 1);
    chk("pal_addr", s_addr, 14'h3F01);
    chk("pal_rdata", cpu_rdata, exp_pal);
    load_ptr(14'h2000);
    vram_rdata = 8'h56;
    access(1'b0, 8'h00, 0, 1);
    chk("pal_buf", cpu_rdata, 8'h55);

    // Reset while in CAPTURE
    load_ptr(14'h0100);
    vram_rdata = 8'h66; render_addr = 14'h0ABC;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_wdata = 8'h99;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("cap_busy", cpu_busy, 1);
    chk("cap_strobe", {vram_rd, vram_we}, 0);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", cpu_busy, 0);
    chk("ar_rdata", cpu_rdata, 0);
    chk("ar_strobes", {vram_rd, vram_we}, 0);
    chk("ar_wdata", vram_wdata, 0);
    chk("ar_addr", vram_addr, 14'h0ABC);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    access(1'b1, 8'h12, 0, 1);
    chk("ar_ptr", s_addr, 14'h0000);
    vram_rdata = 8'h77;
    access(1'b0, 8'h00, 0, 1);
    chk("ar_ptr2", s_addr, 14'h0001);
    chk("ar_buf", cpu_rdata, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
